// File: rtl/rr_pkg.sv
// Shared constants and sizing helper for the round-robin arbiter mux.
// No logic, so no latency; backpressure lives in the modules that import this.
// Mode encodings are used as the RR parameter value.
package rr_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index width for n channels, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational one-hot grant among N requests, round-robin from ptr or fixed priority.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller qualifies the grant with its own load enable.
module rr_grant
    import rr_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int RR    = MODE_RR,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [2*N-1:0] dbl_req;

    always_comb begin
        dbl_req = {req, req};
        // Clearing the low copy below ptr leaves ptr..N-1 first, then the wrapped 0..N-1.
        if (RR == MODE_RR) begin
            for (int j = 0; j < N; j++) begin
                if (j < int'(ptr)) dbl_req[j] = 1'b0;
            end
        end

        gnt_idx = '0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (dbl_req[j]) gnt_idx = SEL_W'(j % N);
        end

        grant = '0;
        if (|req) grant[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-way registered channel select with round-robin or fixed-priority arbitration.
// Latency: 1 cycle from input accept to out_valid; 1 word/cycle throughput.
// Backpressure: out_ready combinationally gates in_ready so drain and refill share a cycle.
module rr_arb_mux
    import rr_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int RR    = MODE_RR,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic [SEL_W-1:0]   out_sel_q,   out_sel_d;
    logic [SEL_W-1:0]   ptr_q,       ptr_d;

    logic [N-1:0]       grant;
    logic [SEL_W-1:0]   gnt_idx;
    logic               load_en;
    logic               xfer;
    logic [WIDTH-1:0]   sel_dat;

    rr_grant #(
        .N  (N),
        .RR (RR)
    ) u_grant (
        .req     (in_valid),
        .ptr     (ptr_q),
        .grant   (grant),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        load_en  = !out_valid_q || out_ready;
        in_ready = (load_en && !rst) ? grant : '0;
        xfer     = |in_ready;
        sel_dat  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_dat;
            out_sel_d   = gnt_idx;
            if (RR == MODE_RR) begin
                ptr_d = (int'(gnt_idx) == N-1) ? '0 : gnt_idx + 1'b1;
            end
        end else if (out_ready) begin
            // Drain only: data and index keep their last values.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: round-robin and fixed-priority instances driven by shared stimulus.
// Directed test-plan steps followed by random traffic, checked against a behavioural model.
module tb_rr_arb_mux;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data;
    logic           out_ready = 1'b0;
    logic [W-1:0]   d [N];

    logic [N-1:0]   rdy_rr, rdy_fx;
    logic           vld_rr, vld_fx;
    logic [W-1:0]   dat_rr, dat_fx;
    logic [1:0]     sel_rr, sel_fx;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = fixed priority, 1 = round-robin.
    int           m_vld [2];
    int           m_sel [2];
    int           m_ptr [2];
    logic [W-1:0] m_dat [2];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) in_data[i*W +: W] = d[i];
    end

    rr_arb_mux #(.WIDTH(W), .N(N), .RR(1)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_rr), .out_valid(vld_rr), .out_data(dat_rr),
        .out_sel(sel_rr), .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(W), .N(N), .RR(0)) dut_fx (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_fx), .out_valid(vld_fx), .out_data(dat_fx),
        .out_sel(sel_fx), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requesting channel scanning from the priority start, wrapping modulo N.
    function automatic int winner(input int m, input logic [N-1:0] v);
        int s;
        s = (m == 1) ? m_ptr[1] : 0;
        for (int k = 0; k < N; k++) begin
            if (v[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int m);
        int w;
        w = winner(m, in_valid);
        if (!rst && (m_vld[m] == 0 || out_ready) && w >= 0) return N'(1 << w);
        return '0;
    endfunction

    task automatic check_ready();
        chk("rr_in_ready", 64'(rdy_rr), 64'(exp_ready(1)));
        chk("fx_in_ready", 64'(rdy_fx), 64'(exp_ready(0)));
    endtask

    task automatic check_out();
        chk("rr_out_valid", 64'(vld_rr), 64'(m_vld[1]));
        chk("rr_out_data",  64'(dat_rr), 64'(m_dat[1]));
        chk("rr_out_sel",   64'(sel_rr), 64'(m_sel[1]));
        chk("fx_out_valid", 64'(vld_fx), 64'(m_vld[0]));
        chk("fx_out_data",  64'(dat_fx), 64'(m_dat[0]));
        chk("fx_out_sel",   64'(sel_fx), 64'(m_sel[0]));
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_vld[m] = 0; m_sel[m] = 0; m_ptr[m] = 0; m_dat[m] = '0;
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step(input logic [N-1:0] v, input logic r);
        int           n_vld [2];
        int           n_sel [2];
        int           n_ptr [2];
        logic [W-1:0] n_dat [2];
        int           w;
        in_valid  = v;
        out_ready = r;
        #1;
        check_ready();
        for (int m = 0; m < 2; m++) begin
            n_vld[m] = m_vld[m]; n_sel[m] = m_sel[m];
            n_ptr[m] = m_ptr[m]; n_dat[m] = m_dat[m];
            w = winner(m, v);
            if (!rst && (m_vld[m] == 0 || r) && w >= 0) begin
                n_vld[m] = 1; n_sel[m] = w; n_dat[m] = d[w];
                if (m == 1) n_ptr[m] = (w + 1) % N;
            end else if (r) begin
                n_vld[m] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            m_vld[m] = n_vld[m]; m_sel[m] = n_sel[m];
            m_ptr[m] = n_ptr[m]; m_dat[m] = n_dat[m];
        end
        check_out();
    endtask

    int rot_sel [5] = '{0, 1, 2, 3, 0};

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) d[i] = W'(32'h10 + i);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #2;
        check_out();
        chk("reset_in_ready_rr", 64'(rdy_rr), 64'h0);
        chk("reset_in_ready_fx", 64'(rdy_fx), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin rotation, one word per cycle.
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1'b1);
            chk("rot_valid", 64'(vld_rr), 64'h1);
            chk("rot_sel",   64'(sel_rr), 64'(rot_sel[k]));
            chk("rot_data",  64'(dat_rr), 64'(32'h10 + rot_sel[k]));
        end

        // Load channel 2, stall three cycles, then release.
        step(4'b0100, 1'b1);
        chk("stall_load_data", 64'(dat_rr), 64'h12);
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 1'b0);
            chk("stall_rdy",  64'(rdy_rr), 64'h0);
            chk("stall_data", 64'(dat_rr), 64'h12);
            chk("stall_sel",  64'(sel_rr), 64'h2);
        end
        step(4'b1111, 1'b1);
        chk("stall_release_sel", 64'(sel_rr), 64'h3);

        // Fixed priority: channel 1 always beats channel 3.
        for (int k = 0; k < 4; k++) begin
            step(4'b1010, 1'b1);
            chk("fixed_sel", 64'(sel_fx), 64'h1);
        end

        // Wrap with sparse requests from ptr=3.
        step(4'b0100, 1'b1);
        step(4'b0101, 1'b1);
        chk("wrap_sel0", 64'(sel_rr), 64'h0);
        step(4'b0101, 1'b1);
        chk("wrap_sel2", 64'(sel_rr), 64'h2);

        // Drain with nothing requesting.
        step(4'b0000, 1'b1);
        chk("drain_valid", 64'(vld_rr), 64'h0);
        chk("drain_data",  64'(dat_rr), 64'h12);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) d[i] = $urandom;
            step(N'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
        end

        // Reset asserted between edges with a word held.
        d[0] = 32'hDEADBEEF;
        step(4'b0001, 1'b1);
        chk("pre_reset_data", 64'(dat_rr), 64'hDEADBEEF);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_out();
        chk("midrst_rdy_rr", 64'(rdy_rr), 64'h0);
        out_ready = 1'b1;
        #1;
        chk("midrst_rdy_rr_ordy", 64'(rdy_rr), 64'h0);
        chk("midrst_rdy_fx_ordy", 64'(rdy_fx), 64'h0);
        @(posedge clk);
        #1;
        check_out();
        rst = 1'b0;
        step(4'b1111, 1'b1);
        chk("post_reset_sel", 64'(sel_rr), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
